fadd_scheduler: RTL and testbench

Round-robin scheduler that shares a single FloatAdder among `N_REQ` requesters. It latches the winning requester's two FP16 operands and drives the adder's Start/operand pins. It waits for the adder's Done (bounded by a timeout) and returns the 16-bit result to the winner with a one-cycle response pulse. It sits between the processor's FP-issue sources and the one FloatAdder instance.

---
 rtl/fadd_scheduler_pkg.sv | 19 +
 rtl/fadd_scheduler_if.sv | 33 +++
 rtl/fadd_scheduler_rr_arbiter.sv | 30 +++
 rtl/fadd_scheduler.sv | 140 ++++++++++++++
 tb/tb_fadd_scheduler.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fadd_scheduler_pkg.sv
// Shared types and constants for the FloatAdder round-robin scheduler.
package fadd_sched_pkg;

   localparam int FP16_W = 16;
   localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } fadd_sched_state_t;

   // Wrap a requester position that may run past the last requester.
   function automatic int rr_wrap(input int pos, input int n);
      return (pos >= n) ? pos - n : pos;
   endfunction

endpackage

// File: rtl/fadd_scheduler_if.sv
// Requester and FloatAdder pins of the scheduler, bundled for port connection.
interface fadd_scheduler_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    Req;
   logic [16*N_REQ-1:0] Op_A;
   logic [16*N_REQ-1:0] Op_B;
   logic [N_REQ-1:0]    Grant;
   logic [N_REQ-1:0]    Resp_Valid;
   logic [15:0]         Result;
   logic                Resp_Err;
   logic                Busy;
   logic                Fa_Start;
   logic [7:0]          Fa_A_MSB;
   logic [7:0]          Fa_A_LSB;
   logic [7:0]          Fa_B_MSB;
   logic [7:0]          Fa_B_LSB;
   logic [7:0]          Fa_Result_MSB;
   logic [7:0]          Fa_Result_LSB;
   logic                Fa_Done;

   modport slave (
      input  Req, Op_A, Op_B, Fa_Result_MSB, Fa_Result_LSB, Fa_Done,
      output Grant, Resp_Valid, Result, Resp_Err, Busy, Fa_Start,
             Fa_A_MSB, Fa_A_LSB, Fa_B_MSB, Fa_B_LSB
   );

   modport master (
      output Req, Op_A, Op_B, Fa_Result_MSB, Fa_Result_LSB, Fa_Done,
      input  Grant, Resp_Valid, Result, Resp_Err, Busy, Fa_Start,
             Fa_A_MSB, Fa_A_LSB, Fa_B_MSB, Fa_B_LSB
   );
endinterface

// File: rtl/fadd_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter
   import fadd_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      // Scan from the farthest position down so the nearest hit is the last one written.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_i[rr_wrap(int'(ptr_i) + k, N_REQ)]) begin
            grant_o = '0;
            grant_o[rr_wrap(int'(ptr_i) + k, N_REQ)] = 1'b1;
            idx_o   = IDX_W'(rr_wrap(int'(ptr_i) + k, N_REQ));
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fadd_scheduler.sv
// Shares one FloatAdder among N_REQ requesters; the adder sits beside this block
// at integration with its Reset tied to ~Reset_n.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for any Req; latch winner and operands on exit
// S_ISSUE   | Fa_Start and Grant pulse; timeout counter cleared
// S_WAIT    | operands held; wait for Fa_Done or timeout
// S_RESPOND | Resp_Valid pulse with Result/Resp_Err; advance rr_ptr
module fadd_scheduler
   import fadd_sched_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 31
) (
   input  logic Clk,
   input  logic Reset_n,
   fadd_scheduler_if.slave sched
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   fadd_sched_state_t   state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [FP16_W-1:0]   op_a_q, op_a_d;
   logic [FP16_W-1:0]   op_b_q, op_b_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [N_REQ-1:0]    resp_valid_q, resp_valid_d;
   logic [FP16_W-1:0]   result_q, result_d;
   logic                err_q, err_d;
   logic                fa_start_q, fa_start_d;
   logic [7:0]          cnt_q, cnt_d;

   logic [N_REQ-1:0]    win_onehot;
   logic [IDX_W-1:0]    win_idx;
   logic                win_valid;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i   (sched.Req),
      .ptr_i   (rr_ptr_q),
      .grant_o (win_onehot),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         idx_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         grant_q      <= '0;
         resp_valid_q <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
         fa_start_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         idx_q        <= idx_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         grant_q      <= grant_d;
         resp_valid_q <= resp_valid_d;
         result_q     <= result_d;
         err_q        <= err_d;
         fa_start_q   <= fa_start_d;
         cnt_q        <= cnt_d;
      end
   end

   // Pulse outputs default low so Result/Resp_Err read zero outside a response.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      idx_d        = idx_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      cnt_d        = cnt_q;
      grant_d      = '0;
      resp_valid_d = '0;
      result_d     = '0;
      err_d        = 1'b0;
      fa_start_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (win_valid) begin
               idx_d      = win_idx;
               op_a_d     = sched.Op_A[int'(win_idx) * FP16_W +: FP16_W];
               op_b_d     = sched.Op_B[int'(win_idx) * FP16_W +: FP16_W];
               grant_d    = win_onehot;
               fa_start_d = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (sched.Fa_Done) begin
               result_d     = {sched.Fa_Result_MSB, sched.Fa_Result_LSB};
               resp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
               state_d      = S_RESPOND;
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               result_d     = FP16_QNAN;
               err_d        = 1'b1;
               resp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
               state_d      = S_RESPOND;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESPOND: begin
            rr_ptr_d = IDX_W'(rr_wrap(int'(idx_q) + 1, N_REQ));
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sched.Grant      = grant_q;
   assign sched.Resp_Valid = resp_valid_q;
   assign sched.Result     = result_q;
   assign sched.Resp_Err   = err_q;
   assign sched.Fa_Start   = fa_start_q;
   assign sched.Fa_A_MSB   = op_a_q[15:8];
   assign sched.Fa_A_LSB   = op_a_q[7:0];
   assign sched.Fa_B_MSB   = op_b_q[15:8];
   assign sched.Fa_B_LSB   = op_b_q[7:0];
   assign sched.Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fadd_scheduler.sv
// Scoreboard bench for fadd_scheduler with a behavioural FloatAdder stub.
module tb_fadd_scheduler;

   localparam int N  = 4;
   localparam int TO = 31;

   typedef struct {
      int          idx;
      int          cyc;
      logic [15:0] a;
      logic [15:0] b;
   } gexp_t;

   typedef struct {
      int          idx;
      int          cyc;
      logic [15:0] res;
      logic        err;
   } rexp_t;

   logic Clk;
   logic Reset_n;
   int   cyc;
   int   n_pass;
   int   n_total;

   gexp_t gq[$];
   rexp_t rq[$];

   // adder stub controls
   int          stub_dly;
   logic        stub_never;
   logic        stub_override;
   logic [15:0] stub_res;
   int          dcnt;

   logic [15:0] ta [N];
   logic [15:0] tb_ops [N];

   fadd_scheduler_if #(.N_REQ(N)) sif ();

   fadd_scheduler #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .sched   (sif)
   );

   function automatic logic [15:0] stub_fn(input logic [15:0] a, input logic [15:0] b);
      return {a[15:8] + b[15:8], a[7:0] ^ b[7:0]};
   endfunction

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc++;

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)          dcnt <= 0;
      else if (sif.Fa_Start) dcnt <= stub_dly;
      else if (dcnt != 0)    dcnt <= dcnt - 1;
   end

   assign sif.Fa_Done = !stub_never && (dcnt == 1);
   assign {sif.Fa_Result_MSB, sif.Fa_Result_LSB} = stub_override ? stub_res :
      stub_fn({sif.Fa_A_MSB, sif.Fa_A_LSB}, {sif.Fa_B_MSB, sif.Fa_B_LSB});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge Clk);
   endtask

   task automatic expect_op(input int idx, input int t, input int resp_lat,
                            input logic [15:0] res, input logic err);
      gexp_t g;
      rexp_t r;
      g.idx = idx; g.cyc = t + 1; g.a = sif.Op_A[16*idx +: 16]; g.b = sif.Op_B[16*idx +: 16];
      r.idx = idx; r.cyc = t + resp_lat; r.res = res; r.err = err;
      gq.push_back(g);
      rq.push_back(r);
   endtask

   task automatic load_ops();
      for (int i = 0; i < N; i++) begin
         sif.Op_A[16*i +: 16] = ta[i];
         sif.Op_B[16*i +: 16] = tb_ops[i];
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_grant"}, 32'(sif.Grant), 0);
      chk({name, "_resp"}, 32'({sif.Resp_Valid, sif.Result, sif.Resp_Err}), 0);
      chk({name, "_busy_start"}, 32'({sif.Busy, sif.Fa_Start}), 0);
      chk({name, "_opbytes"}, {sif.Fa_A_MSB, sif.Fa_A_LSB, sif.Fa_B_MSB, sif.Fa_B_LSB}, 0);
   endtask

   // Monitor: pops and compares whenever the DUT presents a Grant or Resp_Valid.
   initial begin
      gexp_t g;
      rexp_t r;
      forever begin
         @(negedge Clk);
         if (sif.Grant != '0) begin
            if (gq.size() == 0) chk("grant_unexpected", 32'(sif.Grant), 0);
            else begin
               g = gq.pop_front();
               chk("grant_vec", 32'(sif.Grant), 32'(1) << g.idx);
               chk("grant_cycle", cyc, g.cyc);
               chk("grant_fa_start", 32'(sif.Fa_Start), 1);
               chk("grant_fa_a", 32'({sif.Fa_A_MSB, sif.Fa_A_LSB}), 32'(g.a));
               chk("grant_fa_b", 32'({sif.Fa_B_MSB, sif.Fa_B_LSB}), 32'(g.b));
            end
         end else begin
            chk("fa_start_idle", 32'(sif.Fa_Start), 0);
         end
         if (sif.Resp_Valid != '0) begin
            if (rq.size() == 0) chk("resp_unexpected", 32'(sif.Resp_Valid), 0);
            else begin
               r = rq.pop_front();
               chk("resp_vec", 32'(sif.Resp_Valid), 32'(1) << r.idx);
               chk("resp_cycle", cyc, r.cyc);
               chk("resp_result", 32'(sif.Result), 32'(r.res));
               chk("resp_err", 32'(sif.Resp_Err), 32'(r.err));
            end
         end else begin
            chk("resp_quiet_zero", 32'({sif.Result, sif.Resp_Err}), 0);
         end
      end
   end

   initial begin
      int t;
      cyc = 0; n_pass = 0; n_total = 0;
      stub_dly = 7; stub_never = 1'b0; stub_override = 1'b0; stub_res = '0;
      ta     = '{16'h3C00, 16'h4100, 16'hC500, 16'h0001};
      tb_ops = '{16'h4000, 16'h3800, 16'h4500, 16'h8001};
      Reset_n = 1'b0;
      sif.Req = '0; sif.Op_A = '0; sif.Op_B = '0;

      // reset state
      @(negedge Clk);
      chk_all_zero("reset");
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // single request with fixed adder result
      stub_override = 1'b1; stub_res = 16'h4200;
      t = cyc;
      sif.Op_A[15:0] = 16'h3C00; sif.Op_B[15:0] = 16'h4000;
      sif.Req = 4'b0001;
      chk("single_busy_idle", 32'(sif.Busy), 0);
      expect_op(0, t, 9, 16'h4200, 1'b0);
      wait_until(t + 5);
      chk("single_busy_wait", 32'(sif.Busy), 1);
      wait_until(t + 9);
      sif.Req = '0;
      wait_until(t + 10);
      chk("single_busy_back_idle", 32'(sif.Busy), 0);
      wait_until(t + 12);
      stub_override = 1'b0;

      // all four after reset: order 0,1,2,3 ten cycles apart
      do_reset();
      load_ops();
      t = cyc;
      sif.Req = 4'b1111;
      for (int k = 0; k < N; k++)
         expect_op(k, t + 10*k, 9, stub_fn(ta[k], tb_ops[k]), 1'b0);
      for (int k = 0; k < N; k++) begin
         wait_until(t + 9 + 10*k);
         sif.Req[k] = 1'b0;
      end
      wait_until(t + 42);

      // requesters 1 and 3 held: 1,3,1,3
      t = cyc;
      sif.Req = 4'b1010;
      expect_op(1, t,      9, stub_fn(ta[1], tb_ops[1]), 1'b0);
      expect_op(3, t + 10, 9, stub_fn(ta[3], tb_ops[3]), 1'b0);
      expect_op(1, t + 20, 9, stub_fn(ta[1], tb_ops[1]), 1'b0);
      expect_op(3, t + 30, 9, stub_fn(ta[3], tb_ops[3]), 1'b0);
      wait_until(t + 39);
      sif.Req = '0;
      wait_until(t + 42);

      // timeout, then a normal request
      stub_never = 1'b1;
      t = cyc;
      sif.Req = 4'b0001;
      expect_op(0, t, 2 + TO, 16'h7E00, 1'b1);
      wait_until(t + 2 + TO);
      sif.Req = '0;
      stub_never = 1'b0;
      wait_until(t + 4 + TO);
      t = cyc;
      sif.Req = 4'b0100;
      expect_op(2, t, 9, stub_fn(ta[2], tb_ops[2]), 1'b0);
      wait_until(t + 9);
      sif.Req = '0;
      wait_until(t + 11);

      // Done in the same cycle the timeout would fire: Done wins
      stub_dly = TO;
      t = cyc;
      sif.Req = 4'b1000;
      expect_op(3, t, 2 + TO, stub_fn(ta[3], tb_ops[3]), 1'b0);
      wait_until(t + 2 + TO);
      sif.Req = '0;
      stub_dly = 7;
      wait_until(t + 4 + TO);

      // operand change after Grant does not disturb held operands
      t = cyc;
      sif.Op_A[15:0] = 16'h1234; sif.Op_B[15:0] = 16'h5678;
      sif.Req = 4'b0001;
      expect_op(0, t, 9, stub_fn(16'h1234, 16'h5678), 1'b0);
      wait_until(t + 2);
      sif.Op_A[15:0] = 16'hFFFF;
      for (int c = 3; c <= 8; c++) begin
         wait_until(t + c);
         chk("hold_fa_a", 32'({sif.Fa_A_MSB, sif.Fa_A_LSB}), 32'h1234);
      end
      wait_until(t + 9);
      sif.Req = '0;
      wait_until(t + 11);
      load_ops();

      // reset during WAIT discards the operation
      t = cyc;
      sif.Req = 4'b0100;
      begin
         gexp_t g;
         g.idx = 2; g.cyc = t + 1; g.a = ta[2]; g.b = tb_ops[2];
         gq.push_back(g);
      end
      wait_until(t + 5);
      Reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      sif.Req = '0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      t = cyc;
      sif.Req = 4'b0110;
      expect_op(1, t, 9, stub_fn(ta[1], tb_ops[1]), 1'b0);
      wait_until(t + 9);
      sif.Req = 4'b0100;
      expect_op(2, t + 10, 9, stub_fn(ta[2], tb_ops[2]), 1'b0);
      wait_until(t + 19);
      sif.Req = '0;
      wait_until(t + 24);

      chk("grants_left", gq.size(), 0);
      chk("resps_left", rq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
